// File: rtl/f1_lights_rx.sv
// Start-light receiver: checks the thermometer light sequence, detects lights out
// and measures the driver's reaction time in clock cycles.
module f1_lights_rx #(
  parameter int N_LIGHTS  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_LIGHTS-1:0]  data_in,
  input  logic                 trigger,
  output logic [3:0]           light_count,
  output logic                 armed,
  output logic                 go,
  output logic                 jump_start,
  output logic                 react_valid,
  output logic [CNT_WIDTH-1:0] react_time,
  output logic                 seq_error
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] COUNTING = 3'd1;
  localparam logic [2:0] ARMED    = 3'd2;
  localparam logic [2:0] TIMING   = 3'd3;
  localparam logic [2:0] ERROR    = 3'd4;

  logic [2:0]           state;
  logic [3:0]           last;
  logic [3:0]           last_inc;
  logic [CNT_WIDTH-1:0] counter;
  logic [3:0]           pop;
  logic [N_LIGHTS-1:0]  code_inc;
  logic                 code_ok;
  logic                 is_zero;
  logic                 is_full;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_LIGHTS; i++) pop = pop + 4'(data_in[i]);
  end

  // 2^k-1 patterns are exactly those with no set bit above a clear bit
  assign code_inc = data_in + N_LIGHTS'(1);
  assign code_ok  = (data_in & code_inc) == '0;
  assign is_zero  = data_in == '0;
  assign is_full  = data_in == '1;
  assign last_inc = last + 4'd1;

  assign armed     = state == ARMED;
  assign seq_error = state == ERROR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= '0;
      counter     <= '0;
      light_count <= '0;
      react_time  <= '0;
      go          <= 1'b0;
      jump_start  <= 1'b0;
      react_valid <= 1'b0;
    end else begin
      go          <= 1'b0;
      jump_start  <= 1'b0;
      react_valid <= 1'b0;
      if (en) light_count <= pop;
      case (state)
        IDLE: begin
          if (en && !is_zero) begin
            if (data_in == N_LIGHTS'(1)) begin
              state <= COUNTING;
              last  <= 4'd1;
            end else begin
              state <= ERROR;
            end
          end
        end
        COUNTING: begin
          if (trigger) begin
            jump_start <= 1'b1;
            state      <= IDLE;
          end else if (en) begin
            if (code_ok && pop == last) begin
              state <= COUNTING;
            end else if (code_ok && pop == last_inc) begin
              last <= last_inc;
              if (last_inc == 4'(N_LIGHTS)) state <= ARMED;
            end else begin
              state <= ERROR;
            end
          end
        end
        ARMED: begin
          if (trigger) begin
            jump_start <= 1'b1;
            state      <= IDLE;
          end else if (en) begin
            if (is_zero) begin
              state   <= TIMING;
              go      <= 1'b1;
              counter <= '0;
            end else if (!is_full) begin
              state <= ERROR;
            end
          end
        end
        TIMING: begin
          if (trigger) begin
            react_time  <= counter;
            react_valid <= 1'b1;
            state       <= IDLE;
          end else if (counter == '1) begin
            // no reaction within counter range: report saturated time
            react_time  <= '1;
            react_valid <= 1'b1;
            state       <= IDLE;
          end else begin
            counter <= counter + CNT_WIDTH'(1);
          end
        end
        ERROR: begin
          if (en && is_zero) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_lights_rx.sv
// Directed bench for f1_lights_rx: a default instance plus a CNT_WIDTH=4 instance for timeout.
module tb_f1_lights_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        trigger = 1'b0;

  logic [3:0]  light_count, light_count4;
  logic        armed, go, jump_start, react_valid, seq_error;
  logic        armed4, go4, jump_start4, react_valid4, seq_error4;
  logic [15:0] react_time;
  logic [3:0]  react_time4;

  int n_cmp = 0;
  int n_bad = 0;

  f1_lights_rx dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .trigger(trigger),
    .light_count(light_count), .armed(armed), .go(go), .jump_start(jump_start),
    .react_valid(react_valid), .react_time(react_time), .seq_error(seq_error)
  );

  f1_lights_rx #(.N_LIGHTS(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .trigger(trigger),
    .light_count(light_count4), .armed(armed4), .go(go4), .jump_start(jump_start4),
    .react_valid(react_valid4), .react_time(react_time4), .seq_error(seq_error4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] d);
    en = 1'b1; data_in = d; tick();
  endtask

  task automatic drive_to_armed();
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k <= 8; k++) begin
      sample(c);
      c = {c[6:0], 1'b1};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; trigger = 1'b0;
    tick(); tick();
    n_cmp++; if (light_count !== 4'd0) begin n_bad++; $display("FAIL reset_light_count got %0d want 0", light_count); end
    n_cmp++; if ({armed, go, jump_start, react_valid, seq_error} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got %b want 00000", {armed, go, jump_start, react_valid, seq_error}); end
    n_cmp++; if (react_time !== 16'd0) begin n_bad++; $display("FAIL reset_react_time got %0d want 0", react_time); end
    rst = 1'b0;
  endtask

  task automatic test_legal();
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k <= 8; k++) begin
      sample(c);
      n_cmp++; if (light_count !== 4'(k)) begin n_bad++; $display("FAIL legal_light_count[%0d] got %0d want %0d", k, light_count, k); end
      n_cmp++; if (seq_error !== 1'b0) begin n_bad++; $display("FAIL legal_seq_error[%0d] got %b want 0", k, seq_error); end
      n_cmp++; if (armed !== (k == 8)) begin n_bad++; $display("FAIL legal_armed[%0d] got %b want %b", k, armed, k == 8); end
      c = {c[6:0], 1'b1};
    end
    sample(8'h00);
    n_cmp++; if (go !== 1'b1) begin n_bad++; $display("FAIL legal_go got %b want 1", go); end
    n_cmp++; if (light_count !== 4'd0) begin n_bad++; $display("FAIL legal_lights_out_count got %0d want 0", light_count); end
    n_cmp++; if (armed !== 1'b0) begin n_bad++; $display("FAIL legal_armed_after_go got %b want 0", armed); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if ({go, react_valid} !== 2'b00) begin n_bad++; $display("FAIL legal_timing_quiet[%0d] got %b want 00", i, {go, react_valid}); end
    end
    trigger = 1'b1; tick(); trigger = 1'b0;
    n_cmp++; if (react_valid !== 1'b1) begin n_bad++; $display("FAIL legal_react_valid got %b want 1", react_valid); end
    n_cmp++; if (react_time !== 16'd5) begin n_bad++; $display("FAIL legal_react_time got %0d want 5", react_time); end
    tick();
    n_cmp++; if (react_valid !== 1'b0) begin n_bad++; $display("FAIL legal_react_pulse_width got %b want 0", react_valid); end
    n_cmp++; if (react_time !== 16'd5) begin n_bad++; $display("FAIL legal_react_time_hold got %0d want 5", react_time); end
  endtask

  task automatic test_jump_start();
    sample(8'h00); sample(8'h01); sample(8'h03); sample(8'h07); sample(8'h0F);
    trigger = 1'b1; data_in = 8'h1F; tick(); trigger = 1'b0;
    n_cmp++; if (jump_start !== 1'b1) begin n_bad++; $display("FAIL jump_pulse got %b want 1", jump_start); end
    n_cmp++; if ({go, react_valid, seq_error} !== 3'b000) begin n_bad++; $display("FAIL jump_other_flags got %b want 000", {go, react_valid, seq_error}); end
    // 0x00 stays quiet only if the FSM really went back to IDLE
    sample(8'h00);
    n_cmp++; if (jump_start !== 1'b0) begin n_bad++; $display("FAIL jump_pulse_width got %b want 0", jump_start); end
    n_cmp++; if (seq_error !== 1'b0) begin n_bad++; $display("FAIL jump_back_idle got %b want 0", seq_error); end
  endtask

  task automatic test_armed_jump();
    drive_to_armed();
    trigger = 1'b1; data_in = 8'h00; tick(); trigger = 1'b0;
    n_cmp++; if ({jump_start, go} !== 2'b10) begin n_bad++; $display("FAIL armed_jump got %b want 10", {jump_start, go}); end
    tick();
    n_cmp++; if ({armed, go, react_valid} !== 3'b000) begin n_bad++; $display("FAIL armed_jump_idle got %b want 000", {armed, go, react_valid}); end
  endtask

  task automatic test_illegal();
    sample(8'h01); sample(8'h03); sample(8'h05);
    n_cmp++; if (seq_error !== 1'b1) begin n_bad++; $display("FAIL illegal_seq_error got %b want 1", seq_error); end
    n_cmp++; if (light_count !== 4'd2) begin n_bad++; $display("FAIL illegal_light_count got %0d want 2", light_count); end
    sample(8'hFF);
    trigger = 1'b1; sample(8'hFF); trigger = 1'b0;
    n_cmp++; if ({seq_error, armed, jump_start} !== 3'b100) begin n_bad++; $display("FAIL illegal_hold got %b want 100", {seq_error, armed, jump_start}); end
    sample(8'h00);
    n_cmp++; if (seq_error !== 1'b0) begin n_bad++; $display("FAIL illegal_clear got %b want 0", seq_error); end
    drive_to_armed();
    n_cmp++; if (armed !== 1'b1) begin n_bad++; $display("FAIL illegal_rearm got %b want 1", armed); end
    sample(8'h00);
    tick(); tick(); tick();
    trigger = 1'b1; tick(); trigger = 1'b0;
    n_cmp++; if ({react_valid, react_time} !== {1'b1, 16'd3}) begin n_bad++; $display("FAIL illegal_measure got %b/%0d want 1/3", react_valid, react_time); end
  endtask

  task automatic test_skip_hold();
    sample(8'h01); sample(8'h03); sample(8'h03);
    n_cmp++; if ({seq_error, light_count} !== {1'b0, 4'd2}) begin n_bad++; $display("FAIL skip_hold got %b/%0d want 0/2", seq_error, light_count); end
    sample(8'h0F);
    n_cmp++; if (seq_error !== 1'b1) begin n_bad++; $display("FAIL skip_error got %b want 1", seq_error); end
    sample(8'h00);
  endtask

  task automatic test_timeout();
    bit found;
    int lat;
    found = 1'b0; lat = 0;
    drive_to_armed();
    sample(8'h00);
    en = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      tick();
      if (react_valid4) begin found = 1'b1; lat = i; end
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL timeout_seen got %b want 1", found); end
    n_cmp++; if (lat != 16) begin n_bad++; $display("FAIL timeout_latency got %0d want 16", lat); end
    n_cmp++; if (react_time4 !== 4'hF) begin n_bad++; $display("FAIL timeout_time got %h want f", react_time4); end
    n_cmp++; if (react_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_wide_still_timing got %b want 0", react_valid); end
    // only the narrow instance is back in IDLE, so 0x05 errors it alone
    sample(8'h05);
    n_cmp++; if ({seq_error4, seq_error} !== 2'b10) begin n_bad++; $display("FAIL timeout_idle got %b want 10", {seq_error4, seq_error}); end
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
  endtask

  task automatic test_reset_mid_timing();
    drive_to_armed();
    sample(8'h00);
    en = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if ({armed, go, jump_start, react_valid, seq_error} !== 5'b0) begin n_bad++; $display("FAIL rstmid_flags got %b want 00000", {armed, go, jump_start, react_valid, seq_error}); end
    n_cmp++; if ({light_count, react_time} !== 20'd0) begin n_bad++; $display("FAIL rstmid_regs got %0d/%0d want 0/0", light_count, react_time); end
    trigger = 1'b1; tick(); trigger = 1'b0;
    tick();
    n_cmp++; if ({react_valid, jump_start, react_time} !== 18'd0) begin n_bad++; $display("FAIL rstmid_late_trigger got %b/%b/%0d want 0/0/0", react_valid, jump_start, react_time); end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_jump_start();
    test_armed_jump();
    test_illegal();
    test_skip_hold();
    test_timeout();
    test_reset_mid_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/f1_lights_rx.md
Name: f1_lights_rx

Overview:
- Receiving end of the start-light interface: monitors the 8-bit thermometer light pattern (0x00, 0x01, 0x03 … 0xFF) that the light sequencer drives.
- Checks that the sequence is legal and detects "lights out" (0xFF → 0x00).
- Measures the driver's reaction time in clock cycles, from lights out to the trigger input.
- Sits between the light sequencer and the scoring/display logic.

Parameters:
- N_LIGHTS, 8, number of lights / width of data_in. The block is verified at 8 only.
- CNT_WIDTH, 16, width of the reaction-time counter and react_time.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample strobe: data_in is evaluated only in cycles where en=1.
- data_in  input  N_LIGHTS  light pattern from the sequencer.
- trigger  input  1  driver button, level-sampled every clk.
- light_count  output  4  popcount of the last sampled data_in (0..8), registered.
- armed  output  1  high while the FSM is in ARMED.
- go  output  1  one-cycle pulse when lights out is detected.
- jump_start  output  1  one-cycle pulse when trigger is seen before lights out.
- react_valid  output  1  one-cycle pulse; react_time is valid in that cycle.
- react_time  output  CNT_WIDTH  last measured reaction time. Holds until the next react_valid.
- seq_error  output  1  high while the FSM is in ERROR.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State = IDLE, last=0, counter=0.
  - light_count=0, react_time=0, and every pulse/flag output = 0.
  - rst dominates all other inputs in any state, including mid-TIMING; no react_valid is produced in that case.
- Valid code: data_in == 2^k−1 for k in 0..8. Any other value is invalid.
- light_count: on every en=1 cycle (any state), light_count <= popcount(data_in) at the next edge.
- States and transitions (all registered; outputs are registered pulses unless noted):
  - IDLE:
    - en with 0x00 → stay.
    - en with 0x01 → COUNTING, last=1.
    - en with any other value → ERROR.
    - trigger is ignored.
  - COUNTING (last = 1..7):
    - trigger=1 → jump_start pulse, → IDLE. This has priority over en in the same cycle.
    - en with valid count == last → hold.
    - en with count == last+1 → last+1; if that value is 8 → ARMED.
    - en with anything else → ERROR.
  - ARMED (armed=1, decoded combinationally from state):
    - trigger=1 → jump_start, → IDLE. This has priority even if en brings 0x00 in the same cycle.
    - en with 0xFF → hold.
    - en with 0x00 → TIMING, go pulse, counter <= 0.
    - en with any other value → ERROR.
  - TIMING:
    - en/data_in are ignored.
    - trigger=1 → react_time <= counter, react_valid pulse, → IDLE.
    - Otherwise counter increments by 1 each clk.
    - If the counter reaches all-ones without a trigger → react_time <= all-ones (timeout), react_valid pulse, → IDLE.
    - A trigger in the first TIMING cycle gives react_time=0. Latency is therefore the number of TIMING cycles before trigger.
  - ERROR (seq_error=1):
    - Only an en with 0x00 exits, → IDLE, and seq_error drops with the state.
    - trigger is ignored.
- Pulse timing: go, jump_start and react_valid assert for exactly the one cycle following the triggering edge and never overlap.
- Unused state encodings → IDLE.

Test Plan:
1. Legal sequence: reset, then en=1 every cycle with 0x00,0x01,…,0xFF,0x00, trigger asserted 5 clks after go. Required: armed high after the 0xFF sample, go pulses once, react_valid pulses with react_time=5, seq_error stays 0, light_count tracks 0..8..0.
2. Jump start: same sequence, but trigger=1 while data_in=0x0F has been sampled (COUNTING, last=4). Required: jump_start pulses once, FSM returns to IDLE, no go, no react_valid.
3. Illegal code: after 0x03, sample 0x05. Required: seq_error=1 and held through further 0xFF samples; sampling 0x00 clears it. The following full sequence then measures normally.
4. Skip and hold: after 0x03, sample 0x03 again (holds, no error), then sample 0x0F (count jump 2→4). Required: seq_error=1.
5. Timeout: with CNT_WIDTH=4, lights out and no trigger. Required: react_valid pulses with react_time=0xF, FSM returns to IDLE.
6. Reset mid-TIMING: assert rst 3 clks after go. Required: all outputs 0 next cycle, no react_valid; a later trigger has no effect.
